// File: rtl/reset_sequencer_pkg.sv
// Shared types for the reset sequencer: FSM state encoding.
package reset_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_HOLD     = 3'd0,
        ST_WAIT_DLY = 3'd1,
        ST_WAIT_RDY = 3'd2,
        ST_DONE     = 3'd3,
        ST_FAULT    = 3'd4
    } state_e;

endpackage

// File: rtl/reset_sequencer_sync_2ff.sv
// Two-flop synchronizer with async active-low reset and a configurable preset value.
module sync_2ff #(
    parameter int unsigned W  = 1,
    parameter logic        RV = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= {W{RV}};
            r_sync <= {W{RV}};
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/reset_sequencer.sv
// Releases N_STAGE reset domains in order, DLY cycles apart, waiting for each ready.
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int unsigned N_STAGE = 4,
    parameter int unsigned DLY     = 100,
    parameter int unsigned TMO     = 1000,
    parameter int unsigned CW      = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           req_i,
    input  logic [N_STAGE-1:0]             rdy_i,
    output logic [N_STAGE-1:0]             rst_out_n,
    output logic [$clog2(N_STAGE+1)-1:0]   stage_o,
    output logic                           done_o,
    output logic                           fault_o
);

    localparam int unsigned SW = $clog2(N_STAGE + 1);

    logic              w_req_s;
    state_e            r_state;
    state_e            w_state_nxt;
    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     w_cnt_nxt;
    logic [SW-1:0]     r_stage;
    logic [SW-1:0]     w_stage_nxt;
    logic [SW-1:0]     w_k;
    logic              w_rdy_k;
    logic [N_STAGE-1:0] r_rst_out_n;
    logic [N_STAGE-1:0] w_rst_nxt;
    logic              r_done;
    logic              w_done_nxt;
    logic              r_fault;
    logic              w_fault_nxt;

    sync_2ff #(
        .W  (1),
        .RV (1'b1)
    ) u_req_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (req_i),
        .o_q   (w_req_s)
    );

    assign w_k     = r_stage - SW'(1);
    assign w_rdy_k = rdy_i[w_k];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_HOLD;
            r_cnt       <= '0;
            r_stage     <= '0;
            r_rst_out_n <= '0;
            r_done      <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_stage     <= w_stage_nxt;
            r_rst_out_n <= w_rst_nxt;
            r_done      <= w_done_nxt;
            r_fault     <= w_fault_nxt;
        end
    end

    // A synchronized request overrides every state transition, including a coincident ready.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CW'(1);
        w_stage_nxt = r_stage;
        if (w_req_s) begin
            w_state_nxt = ST_HOLD;
            w_cnt_nxt   = '0;
            w_stage_nxt = '0;
        end else begin
            unique case (r_state)
                ST_HOLD: begin
                    w_state_nxt = ST_WAIT_DLY;
                    w_cnt_nxt   = '0;
                    w_stage_nxt = '0;
                end
                ST_WAIT_DLY: begin
                    if (r_cnt == CW'(DLY - 1)) begin
                        w_state_nxt = ST_WAIT_RDY;
                        w_cnt_nxt   = '0;
                        w_stage_nxt = r_stage + SW'(1);
                    end
                end
                ST_WAIT_RDY: begin
                    if (w_rdy_k) begin
                        w_state_nxt = (w_k == SW'(N_STAGE - 1)) ? ST_DONE : ST_WAIT_DLY;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == CW'(TMO - 1)) begin
                        w_state_nxt = ST_FAULT;
                        w_cnt_nxt   = '0;
                        w_stage_nxt = '0;
                    end
                end
                ST_DONE: begin
                    w_cnt_nxt = '0;
                    if (rdy_i != '1) begin
                        w_state_nxt = ST_FAULT;
                        w_stage_nxt = '0;
                    end
                end
                ST_FAULT: begin
                    w_cnt_nxt   = '0;
                    w_stage_nxt = '0;
                end
                default: begin
                    w_state_nxt = ST_FAULT;
                    w_cnt_nxt   = '0;
                    w_stage_nxt = '0;
                end
            endcase
        end
    end

    always_comb begin
        w_rst_nxt = '0;
        for (int unsigned k = 0; k < N_STAGE; k++) begin
            w_rst_nxt[k] = (k < 32'(w_stage_nxt));
        end
        w_done_nxt  = (w_state_nxt == ST_DONE);
        w_fault_nxt = (w_state_nxt == ST_FAULT);
    end

    assign rst_out_n = r_rst_out_n;
    assign stage_o   = r_stage;
    assign done_o    = r_done;
    assign fault_o   = r_fault;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer (N_STAGE=3, DLY=4, TMO=8).
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_i;
    logic [2:0] rdy_i;
    logic [2:0] rst_out_n;
    logic [1:0] stage_o;
    logic       done_o;
    logic       fault_o;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned edge_n  = 0;

    // One record: edge to check at, inputs applied after that edge, expected outputs.
    typedef struct {
        int unsigned edge_n;
        logic        req;
        logic [2:0]  rdy;
        logic [2:0]  rst;
        logic [1:0]  stage;
        logic        done;
        logic        fault;
    } vec_t;

    vec_t        tbl[16];
    int unsigned tbl_n = 0;
    vec_t        sb_q[$];

    reset_sequencer #(
        .N_STAGE (3),
        .DLY     (4),
        .TMO     (8),
        .CW      (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (req_i),
        .rdy_i     (rdy_i),
        .rst_out_n (rst_out_n),
        .stage_o   (stage_o),
        .done_o    (done_o),
        .fault_o   (fault_o)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input int unsigned e, input logic rq, input logic [2:0] rd,
                                input logic [2:0] rs, input logic [1:0] st,
                                input logic d, input logic f);
        vec_t v;
        v.edge_n = e;
        v.req    = rq;
        v.rdy    = rd;
        v.rst    = rs;
        v.stage  = st;
        v.done   = d;
        v.fault  = f;
        return v;
    endfunction

    task automatic add(input int unsigned e, input logic rq, input logic [2:0] rd,
                       input logic [2:0] rs, input logic [1:0] st,
                       input logic d, input logic f);
        tbl[tbl_n] = mk(e, rq, rd, rs, st, d, f);
        tbl_n++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic check(input string name, input vec_t e);
        n_tests++;
        if (rst_out_n !== e.rst || stage_o !== e.stage || done_o !== e.done || fault_o !== e.fault) begin
            n_fail++;
            $display("FAIL %s edge %0d: got rst_out_n=%b stage=%0d done=%b fault=%b, expected rst_out_n=%b stage=%0d done=%b fault=%b",
                     name, edge_n, rst_out_n, stage_o, done_o, fault_o, e.rst, e.stage, e.done, e.fault);
        end
    endtask

    task automatic hold_req();
        req_i = 1'b1;
        repeat (5) step();
    endtask

    // Drops req_i, then walks edges popping expected records as their edge comes up.
    task automatic run_table(input string name, input logic [2:0] rdy0);
        hold_req();
        sb_q.delete();
        for (int i = 0; i < int'(tbl_n); i++) sb_q.push_back(tbl[i]);
        tbl_n  = 0;
        req_i  = 1'b0;
        rdy_i  = rdy0;
        edge_n = 0;
        while (sb_q.size() > 0 && edge_n < 60) begin
            step();
            while (sb_q.size() > 0 && sb_q[0].edge_n == edge_n) begin
                vec_t e;
                e = sb_q.pop_front();
                check(name, e);
                req_i = e.req;
                rdy_i = e.rdy;
            end
        end
        if (sb_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: %0d expected records not reached within edge budget", name, sb_q.size());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state and idle hold with request asserted.
        rst_n = 1'b0;
        req_i = 1'b1;
        rdy_i = 3'b111;
        #3;
        check("reset", mk(0, 1'b1, 3'b111, 3'b000, 2'd0, 1'b0, 1'b0));
        #4;
        rst_n = 1'b1;
        edge_n = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            check("hold_req", mk(0, 1'b1, 3'b111, 3'b000, 2'd0, 1'b0, 1'b0));
        end

        // Full release with all ready, then ready loss in DONE.
        add( 1, 1'b0, 3'b111, 3'b000, 2'd0, 1'b0, 1'b0);
        add( 6, 1'b0, 3'b111, 3'b000, 2'd0, 1'b0, 1'b0);
        add( 7, 1'b0, 3'b111, 3'b001, 2'd1, 1'b0, 1'b0);
        add(11, 1'b0, 3'b111, 3'b001, 2'd1, 1'b0, 1'b0);
        add(12, 1'b0, 3'b111, 3'b011, 2'd2, 1'b0, 1'b0);
        add(16, 1'b0, 3'b111, 3'b011, 2'd2, 1'b0, 1'b0);
        add(17, 1'b0, 3'b111, 3'b111, 2'd3, 1'b0, 1'b0);
        add(18, 1'b0, 3'b111, 3'b111, 2'd3, 1'b1, 1'b0);
        add(19, 1'b0, 3'b110, 3'b111, 2'd3, 1'b1, 1'b0);
        add(20, 1'b0, 3'b110, 3'b000, 2'd0, 1'b0, 1'b1);
        run_table("seq_all_ready", 3'b111);

        // Stage 1 never ready: timeout fault, then request clears it after 3 edges.
        add(12, 1'b0, 3'b101, 3'b011, 2'd2, 1'b0, 1'b0);
        add(19, 1'b0, 3'b101, 3'b011, 2'd2, 1'b0, 1'b0);
        add(20, 1'b1, 3'b101, 3'b000, 2'd0, 1'b0, 1'b1);
        add(22, 1'b1, 3'b101, 3'b000, 2'd0, 1'b0, 1'b1);
        add(23, 1'b1, 3'b101, 3'b000, 2'd0, 1'b0, 1'b0);
        run_table("timeout", 3'b101);

        // Three-cycle request pulse while waiting to release stage 2, then full restart.
        add( 7, 1'b0, 3'b111, 3'b001, 2'd1, 1'b0, 1'b0);
        add(12, 1'b0, 3'b111, 3'b011, 2'd2, 1'b0, 1'b0);
        add(14, 1'b1, 3'b111, 3'b011, 2'd2, 1'b0, 1'b0);
        add(16, 1'b1, 3'b111, 3'b011, 2'd2, 1'b0, 1'b0);
        add(17, 1'b0, 3'b111, 3'b000, 2'd0, 1'b0, 1'b0);
        add(23, 1'b0, 3'b111, 3'b000, 2'd0, 1'b0, 1'b0);
        add(24, 1'b0, 3'b111, 3'b001, 2'd1, 1'b0, 1'b0);
        add(29, 1'b0, 3'b111, 3'b011, 2'd2, 1'b0, 1'b0);
        add(34, 1'b0, 3'b111, 3'b111, 2'd3, 1'b0, 1'b0);
        add(35, 1'b0, 3'b111, 3'b111, 2'd3, 1'b1, 1'b0);
        run_table("req_pulse", 3'b111);

        // Request and ready arriving on the same edge: request wins.
        add( 7, 1'b1, 3'b000, 3'b001, 2'd1, 1'b0, 1'b0);
        add( 9, 1'b1, 3'b111, 3'b001, 2'd1, 1'b0, 1'b0);
        add(10, 1'b1, 3'b111, 3'b000, 2'd0, 1'b0, 1'b0);
        run_table("req_vs_rdy", 3'b000);

        // Async reset in the middle of WAIT_RDY clears outputs without a clock edge.
        hold_req();
        req_i  = 1'b0;
        rdy_i  = 3'b000;
        edge_n = 0;
        repeat (8) step();
        check("async_pre", mk(8, 1'b0, 3'b000, 3'b001, 2'd1, 1'b0, 1'b0));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", mk(8, 1'b0, 3'b000, 3'b000, 2'd0, 1'b0, 1'b0));
        req_i = 1'b1;
        #2;
        rst_n = 1'b1;
        step();
        check("async_post", mk(0, 1'b1, 3'b000, 3'b000, 2'd0, 1'b0, 1'b0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
